// File: rtl/evt_crossbar_pkg.sv
// Shared types and helpers for the event crossbar arbitration logic.
package evt_crossbar_pkg;

  typedef logic [31:0] evt_t;

  localparam int unsigned EVT_NUM_IN_DEF    = 4;
  localparam int unsigned EVT_DST_PORTS_DEF = 4;

  // Index width that never collapses to zero bits for a single-entry vector.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {OS_EMPTY, OS_FULL} os_state_e;

endpackage

// File: rtl/evt_rr_pick.sv
// Rotate-priority search: first set request strictly after ptr_i, wrapping modulo N.
module evt_rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] pick_o,
  output logic             any_o
);

  // The last candidate examined is ptr_i itself, so a lone requester at the pointer still wins.
  always_comb begin
    int unsigned idx;
    pick_o = '0;
    any_o  = 1'b0;
    idx    = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      idx = (32'(ptr_i) + off) % N;
      if (!any_o && req_i[idx[IDX_W-1:0]]) begin
        any_o  = 1'b1;
        pick_o = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/evt_crossbar_rr_arbiter.sv
// Round-robin arbiter feeding a single-entry output stage for the crossbar broadcast path.
// Optional per-input grant counters are enabled with EVT_CROSSBAR_ARB_STATS_EN.
module evt_crossbar_rr_arbiter
  import evt_crossbar_pkg::*;
#(
  parameter type         T         = evt_t,
  parameter int unsigned NUM_IN    = 4,
  parameter int unsigned DST_PORTS = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  T               [NUM_IN-1:0]         data_i,
  input  logic           [NUM_IN-1:0][DST_PORTS-1:0] mask_i,
  input  logic           [NUM_IN-1:0]         valid_i,
  output logic           [NUM_IN-1:0]         ready_o,
  output T                                    data_o,
  output logic           [DST_PORTS-1:0]      mask_o,
  output logic           [$clog2(NUM_IN)-1:0] gnt_id_o,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic                                drop_o,
  output logic           [NUM_IN-1:0][CNT_W-1:0] gnt_cnt_o,
  input  logic                                clr_cnt_i
);

  localparam int unsigned IDX_W = idx_width(NUM_IN);

  os_state_e            state_q, state_d;
  T                     data_q, data_d;
  logic [DST_PORTS-1:0] mask_q, mask_d;
  logic [IDX_W-1:0]     gnt_id_q, gnt_id_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic                 drop_q, drop_d;

  logic [IDX_W-1:0]     pick;
  logic                 any_req;
  logic                 accept;
  logic                 grant;
  logic                 fwd;
  logic [DST_PORTS-1:0] pick_mask;

  evt_rr_pick #(
    .N     (NUM_IN),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i  (valid_i),
    .ptr_i  (ptr_q),
    .pick_o (pick),
    .any_o  (any_req)
  );

  // Handshake is suppressed during reset so nothing is consumed and then discarded.
  always_comb begin
    accept    = (state_q == OS_EMPTY) || ready_i;
    grant     = accept && any_req && !rst_i;
    pick_mask = mask_i[pick];
    fwd       = grant && (pick_mask != '0);
    ready_o   = '0;
    if (grant) begin
      ready_o[pick] = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    mask_d   = mask_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    drop_d   = 1'b0;
    if (accept) begin
      if (grant) begin
        ptr_d = pick;
        if (fwd) begin
          state_d  = OS_FULL;
          data_d   = data_i[pick];
          mask_d   = pick_mask;
          gnt_id_d = pick;
        end else begin
          // Accept implies empty or draining, so a dropped event always leaves the stage empty.
          state_d = OS_EMPTY;
          drop_d  = 1'b1;
        end
      end else begin
        state_d = OS_EMPTY;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= OS_EMPTY;
      data_q   <= '0;
      mask_q   <= '0;
      gnt_id_q <= '0;
      ptr_q    <= IDX_W'(NUM_IN - 1);
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
      drop_q   <= drop_d;
    end
  end

  assign valid_o  = (state_q == OS_FULL);
  assign data_o   = data_q;
  assign mask_o   = mask_q;
  assign gnt_id_o = gnt_id_q;
  assign drop_o   = drop_q;

`ifdef EVT_CROSSBAR_ARB_STATS_EN
  logic [NUM_IN-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over a same-cycle increment; counts saturate at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt_i) begin
      cnt_d = '0;
    end else if (fwd && (cnt_q[pick] != '1)) begin
      cnt_d[pick] = cnt_q[pick] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign gnt_cnt_o = cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clr_cnt_i;
  assign gnt_cnt_o  = '0;
`endif

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(ready_o));
  assert property (@(posedge clk_i) disable iff (rst_i) ((ready_o & ~valid_i) == '0));
`endif

endmodule

// File: tb/tb_evt_crossbar_rr_arbiter.sv
// Directed, table-driven bench for evt_crossbar_rr_arbiter (default 4 inputs, 4 destinations).
module tb_evt_crossbar_rr_arbiter;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [3:0][31:0]      data_i;
  logic [3:0][3:0]       mask_i;
  logic [3:0]            valid_i;
  logic [3:0]            ready_o;
  logic [31:0]           data_o;
  logic [3:0]            mask_o;
  logic [1:0]            gnt_id_o;
  logic                  valid_o;
  logic                  ready_i;
  logic                  drop_o;
  logic [3:0][15:0]      gnt_cnt_o;
  logic                  clr_cnt_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  evt_crossbar_rr_arbiter dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .data_i    (data_i),
    .mask_i    (mask_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data_o    (data_o),
    .mask_o    (mask_o),
    .gnt_id_o  (gnt_id_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .drop_o    (drop_o),
    .gnt_cnt_o (gnt_cnt_o),
    .clr_cnt_i (clr_cnt_i)
  );

  typedef struct {
    logic [3:0]       valid;
    logic [3:0][31:0] data;
    logic [3:0][3:0]  mask;
    logic             rdy;
    logic [3:0]       exp_ready;
    logic             exp_valid;
    logic [31:0]      exp_data;
    logic [3:0]       exp_mask;
    logic [1:0]       exp_gnt;
    logic             exp_drop;
    bit               chk_pl;
  } vec_t;

  vec_t vecs[$];

  // Input i carries data 0x10+i and mask one-hot at bit i, unless listed in zmask.
  function automatic vec_t mk(input logic [3:0] valid, input logic [3:0] zmask, input logic rdy,
                              input logic [3:0] er, input logic ev, input logic [31:0] ed,
                              input logic [3:0] em, input logic [1:0] eg, input logic edrop,
                              input bit pl);
    vec_t v;
    for (int i = 0; i < 4; i++) begin
      v.data[i] = 32'h10 + 32'(i);
      v.mask[i] = zmask[i] ? 4'b0000 : 4'(1 << i);
    end
    v.valid     = valid;
    v.rdy       = rdy;
    v.exp_ready = er;
    v.exp_valid = ev;
    v.exp_data  = ed;
    v.exp_mask  = em;
    v.exp_gnt   = eg;
    v.exp_drop  = edrop;
    v.chk_pl    = pl;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    valid_i = v.valid;
    data_i  = v.data;
    mask_i  = v.mask;
    ready_i = v.rdy;
  endtask

  // Called at posedge+1: drive, check combinational ready_o, then registered outputs after the edge.
  task automatic runVector(input vec_t v, input int idx);
    applyStimulus(v);
    #4;
    checkOutput($sformatf("v%0d ready_o", idx), 32'(ready_o), 32'(v.exp_ready));
    @(posedge clk_i);
    #1;
    checkOutput($sformatf("v%0d valid_o", idx), 32'(valid_o), 32'(v.exp_valid));
    checkOutput($sformatf("v%0d drop_o", idx), 32'(drop_o), 32'(v.exp_drop));
    if (v.chk_pl) begin
      checkOutput($sformatf("v%0d data_o", idx), data_o, v.exp_data);
      checkOutput($sformatf("v%0d mask_o", idx), 32'(mask_o), 32'(v.exp_mask));
      checkOutput($sformatf("v%0d gnt_id_o", idx), 32'(gnt_id_o), 32'(v.exp_gnt));
    end
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t v;

    rst_i     = 1'b1;
    clr_cnt_i = 1'b0;
    ready_i   = 1'b0;
    valid_i   = 4'b1111;
    mask_i    = '1;
    data_i    = '1;

    vecs.push_back(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0,  4'b0000, 2'd0, 1'b0, 1'b1));
    v = mk(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 32'hA5, 4'b0011, 2'd2, 1'b0, 1'b1);
    v.data[2] = 32'hA5;
    v.mask[2] = 4'b0011;
    vecs.push_back(v);
    vecs.push_back(mk(4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 32'h13, 4'b1000, 2'd3, 1'b0, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 32'h10, 4'b0001, 2'd0, 1'b0, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 32'h11, 4'b0010, 2'd1, 1'b0, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1, 32'h12, 4'b0100, 2'd2, 1'b0, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 32'h13, 4'b1000, 2'd3, 1'b0, 1'b1));
    for (int i = 0; i < 5; i++) begin
      vecs.push_back(mk(4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1, 32'h13, 4'b1000, 2'd3, 1'b0, 1'b1));
    end
    vecs.push_back(mk(4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 32'h10, 4'b0001, 2'd0, 1'b0, 1'b1));
    vecs.push_back(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0,  4'b0000, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b0, 32'h0,  4'b0000, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk(4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1, 32'h12, 4'b0100, 2'd2, 1'b0, 1'b1));
    vecs.push_back(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0,  4'b0000, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 32'h10, 4'b0001, 2'd0, 1'b0, 1'b1));
    vecs.push_back(mk(4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b0, 32'h0,  4'b0000, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 32'h12, 4'b0100, 2'd2, 1'b0, 1'b1));
    vecs.push_back(mk(4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 32'h12, 4'b0100, 2'd2, 1'b0, 1'b1));
    vecs.push_back(mk(4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b0, 32'h0,  4'b0000, 2'd0, 1'b1, 1'b0));

    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset ready_o", 32'(ready_o), 32'h0);
    checkOutput("reset valid_o", 32'(valid_o), 32'h0);
    checkOutput("reset data_o", data_o, 32'h0);
    checkOutput("reset mask_o", 32'(mask_o), 32'h0);
    checkOutput("reset gnt_id_o", 32'(gnt_id_o), 32'h0);
    checkOutput("reset drop_o", 32'(drop_o), 32'h0);
    rst_i = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      runVector(vecs[i], i);
    end

    // Reset while holding a stalled event; the pointer must come back so input 0 wins.
    runVector(mk(4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 32'h10, 4'b0001, 2'd0, 1'b0, 1'b1), 100);
    runVector(mk(4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1, 32'h10, 4'b0001, 2'd0, 1'b0, 1'b1), 101);
    rst_i = 1'b1;
    runVector(mk(4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, 32'h0,  4'b0000, 2'd0, 1'b0, 1'b1), 102);
    rst_i = 1'b0;
    runVector(mk(4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 32'h10, 4'b0001, 2'd0, 1'b0, 1'b1), 103);

`ifdef EVT_CROSSBAR_ARB_STATS_EN
    applyStimulus(mk(4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 32'h10, 4'b0001, 2'd0, 1'b0, 1'b1));
    repeat (70000) @(posedge clk_i);
    #1;
    checkOutput("cnt0 saturated", 32'(gnt_cnt_o[0]), 32'h0000FFFF);
    checkOutput("cnt1 idle", 32'(gnt_cnt_o[1]), 32'h0);
    clr_cnt_i = 1'b1;
    @(posedge clk_i);
    #1;
    checkOutput("cnt0 cleared", 32'(gnt_cnt_o[0]), 32'h0);
    clr_cnt_i = 1'b0;
    @(posedge clk_i);
    #1;
    checkOutput("cnt0 after clear", 32'(gnt_cnt_o[0]), 32'h1);
`else
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("gnt_cnt_o[%0d] tied off", i), 32'(gnt_cnt_o[i]), 32'h0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/evt_crossbar_rr_arbiter.md
Name: evt_crossbar_rr_arbiter

Overview:
- Shares one event crossbar destination path between NUM_IN competing event sources.
- Each source presents an event plus a multicast destination mask.
- The block grants sources round-robin and registers the winner into a single-entry output stage.
- The output stage drives the downstream broadcast stage: data, mask and a valid/ready handshake whose ready is high only when every masked port accepts.
- Sits between the source-side streams and the crossbar destination broadcast logic.

Parameters:
- T, logic [31:0], event payload type.
- NUM_IN, 4, number of requesting source streams (>=2).
- DST_PORTS, 4, width of the multicast destination mask.
- CNT_W, 16, width of the per-input grant counters (optional feature only).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- data_i  in  NUM_IN x T  per-input event payload.
- mask_i  in  NUM_IN x DST_PORTS  per-input destination mask.
- valid_i  in  NUM_IN  per-input valid.
- ready_o  out  NUM_IN  per-input ready; at most one bit high per cycle.
- data_o  out  T  registered event to the broadcast stage.
- mask_o  out  DST_PORTS  registered destination mask.
- gnt_id_o  out  $clog2(NUM_IN)  index of the input that produced the current output.
- valid_o  out  1  output valid.
- ready_i  in  1  downstream ready (all masked destinations accept).
- drop_o  out  1  one-cycle pulse: an event with an all-zero mask was consumed and discarded.
- gnt_cnt_o  out  NUM_IN x CNT_W  grant counters (optional feature).
- clr_cnt_i  in  1  clears grant counters (optional feature).

Behaviour:
- Reset (synchronous, active-high, clk_i domain): valid_o=0, data_o=0, mask_o=0, gnt_id_o=0, drop_o=0, ready_o=0, rr pointer=NUM_IN-1 (so input 0 wins first), counters=0.
- Output stage states:
  - EMPTY: valid_o=0.
  - FULL: valid_o=1.
- accept = (state==EMPTY) || ready_i. Accept is evaluated combinationally each cycle.
- Pick: the first i with valid_i[i]=1, searching from ptr+1 and wrapping modulo NUM_IN.
- If accept is high and any valid_i is set:
  - ready_o[pick]=1 in the same cycle.
  - ptr <= pick on the next edge.
  - If mask_i[pick] != 0: load data_o, mask_o and gnt_id_o; the stage is FULL next cycle.
  - If mask_i[pick] == 0: the event is dropped, drop_o=1 next cycle, and the stage goes EMPTY unless it was FULL and not draining.
- If accept is high and no valid_i is set: a draining FULL stage goes EMPTY; the pointer is unchanged.
- FULL and ready_i=0: hold data_o, mask_o, gnt_id_o and valid_o stable; all ready_o=0.
- Simultaneous drain and load (FULL, ready_i=1, a requester present): back-to-back transfer, stage stays FULL. Throughput is 1 event/cycle.
- Latency: 1 cycle from the input handshake to valid_o.
- Fairness: a continuously requesting input waits at most NUM_IN-1 grants.
- No input may be granted while its valid_i is low. ready_o does not depend on the ready_o outputs themselves, so there is no combinational loop. ready_o depends on ready_i combinationally, as required for full throughput.
- Mid-operation reset: the held event is discarded with no handshake and the pointer is restored to NUM_IN-1.

Optional Feature:
- Macro: EVT_CROSSBAR_ARB_STATS_EN.
- Defined:
  - Per-input CNT_W counters increment on every forwarded grant of that input; dropped events are not counted.
  - Counters saturate at all-ones.
  - clr_cnt_i=1 zeroes all counters on the next edge and has priority over an increment in the same cycle.
- Not defined: gnt_cnt_o is tied to 0, clr_cnt_i is ignored, and no counter flops are instantiated.

Decomposition:
- Package evt_crossbar_pkg holds:
  - default event typedef evt_t;
  - localparam helpers for index width;
  - output-stage state enum {OS_EMPTY, OS_FULL}.
- One sub-module: evt_rr_pick. Combinational rotate-priority search taking req vector and pointer, returning pick index and any_req. It is reused by future crossbar arbiters.

Test Plan:
- Single requester: valid_i=4'b0100, mask 4'b0011, data 0xA5, ready_i=1 -> ready_o=4'b0100 same cycle; next cycle valid_o=1, data_o=0xA5, mask_o=4'b0011, gnt_id_o=2.
- All four inputs requesting continuously, ready_i=1 -> grants 0,1,2,3,0,... one per cycle, valid_o held high.
- Backpressure: ready_i=0 for 5 cycles after a load -> data_o, mask_o and gnt_id_o stable, ready_o=0 throughout; first cycle ready_i=1 -> the next pick is loaded, no bubble.
- Zero mask: input 1 valid with mask 4'b0000 -> ready_o[1]=1, drop_o pulses once, valid_o stays 0; pointer advances so input 2 wins next.
- Reset mid-hold: FULL with ready_i=0, assert rst_i for 1 cycle -> valid_o=0 next cycle; with all inputs then requesting, the first grant is input 0.
- With EVT_CROSSBAR_ARB_STATS_EN: 70000 grants to input 0 with CNT_W=16 -> gnt_cnt_o[0]=0xFFFF; clr_cnt_i pulse -> 0.
